// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP dot-product MAC controller: default widths and FSM states.
package mlp_pkg;

  localparam int MLP_A_WIDTH    = 8;
  localparam int MLP_B_WIDTH    = 8;
  localparam int MLP_ACC_WIDTH  = 32;
  localparam int MLP_ADDR_WIDTH = 8;
  localparam int MLP_OUT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    CAPTURE,
    HOLD
  } mlp_state_e;

endpackage

// File: rtl/mlp_sat_clip.sv
// Combinational signed clip of an IN_WIDTH value to the OUT_WIDTH range, sign-extended back to IN_WIDTH.
// ENABLE=0 makes it a pure pass-through.
module mlp_sat_clip #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter bit ENABLE    = 1'b1
) (
  input  logic signed [IN_WIDTH-1:0] data_i,
  output logic signed [IN_WIDTH-1:0] data_o
);

  localparam logic signed [IN_WIDTH-1:0] MAX_V =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_V =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    data_o = data_i;
    if (ENABLE) begin
      if (data_i > MAX_V) begin
        data_o = MAX_V;
      end else if (data_i < MIN_V) begin
        data_o = MIN_V;
      end
    end
  end

endmodule

// File: rtl/mlp_mac_ctrl.sv
// Streams two vectors from synchronous RAMs into an external MAC and returns the dot product.
// Define MLP_MAC_CTRL_SAT_EN to clip the result to the signed OUT_WIDTH range.
module mlp_mac_ctrl
  import mlp_pkg::*;
#(
  parameter int A_WIDTH    = MLP_A_WIDTH,
  parameter int B_WIDTH    = MLP_B_WIDTH,
  parameter int ACC_WIDTH  = MLP_ACC_WIDTH,
  parameter int ADDR_WIDTH = MLP_ADDR_WIDTH,
  parameter int OUT_WIDTH  = MLP_OUT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_base_a,
  input  logic [ADDR_WIDTH-1:0] cmd_base_b,
  output logic                  mem_a_rd,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  output logic                  mem_b_rd,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  input  logic [A_WIDTH-1:0]    mem_a_data,
  input  logic [B_WIDTH-1:0]    mem_b_data,
  output logic                  mac_start,
  output logic                  mac_valid,
  output logic [A_WIDTH-1:0]    mac_a,
  output logic [B_WIDTH-1:0]    mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data
);

`ifdef MLP_MAC_CTRL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  mlp_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic                  start_q, start_d;
  logic                  valid_q, valid_d;
  logic [ACC_WIDTH-1:0]  res_q, res_d;
  logic [ACC_WIDTH-1:0]  res_proc;
  logic                  rd;
  logic                  drive;

  mlp_sat_clip #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .ENABLE   (SAT_EN)
  ) u_sat (
    .data_i(mac_result),
    .data_o(res_proc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      res_q    <= res_d;
    end
  end

  // STREAM runs len+1 cycles: reads in the first len, the final cycle carries the last MAC drive.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    res_d    = res_q;
    rd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          base_a_d = cmd_base_a;
          base_b_d = cmd_base_b;
          cnt_d    = '0;
          if (cmd_len == '0) begin
            res_d   = '0;
            state_d = HOLD;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        rd      = (cnt_q < len_q);
        start_d = rd && (cnt_q == '0);
        valid_d = rd && (cnt_q != '0);
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d   = res_proc;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign drive      = start_q | valid_q;
  assign cmd_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == HOLD);
  assign res_data   = res_q;
  assign mem_a_rd   = rd;
  assign mem_b_rd   = rd;
  assign mem_a_addr = rd ? (base_a_q + cnt_q[ADDR_WIDTH-1:0]) : '0;
  assign mem_b_addr = rd ? (base_b_q + cnt_q[ADDR_WIDTH-1:0]) : '0;
  assign mac_start  = start_q;
  assign mac_valid  = valid_q;
  assign mac_a      = drive ? mem_a_data : '0;
  assign mac_b      = drive ? mem_b_data : '0;

endmodule

// File: tb/tb_mlp_mac_ctrl.sv
// Self-checking bench for mlp_mac_ctrl: RAM and MAC models plus a dot-product reference.
// Honours MLP_MAC_CTRL_SAT_EN for the expected result.
module tb_mlp_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_len;
  logic [7:0]  cmd_base_a, cmd_base_b;
  logic        mem_a_rd, mem_b_rd;
  logic [7:0]  mem_a_addr, mem_b_addr;
  logic [7:0]  mem_a_data, mem_b_data;
  logic        mac_start, mac_valid;
  logic [7:0]  mac_a, mac_b;
  logic [31:0] mac_result;
  logic        res_valid, res_ready;
  logic [31:0] res_data;

  logic signed [7:0] memA [256];
  logic signed [7:0] memB [256];
  int          macAcc;
  int          numChecks = 0;
  int          numFails  = 0;

  int          rdA = 0, rdB = 0, startCnt = 0, validCnt = 0, overlapCnt = 0, addrErrs = 0;
  int          monIdxA = 0, monIdxB = 0;
  logic [7:0]  monBaseA = '0, monBaseB = '0;

  always #5 clk = ~clk;

  mlp_mac_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_base_a(cmd_base_a),
    .cmd_base_b(cmd_base_b),
    .mem_a_rd  (mem_a_rd),
    .mem_a_addr(mem_a_addr),
    .mem_b_rd  (mem_b_rd),
    .mem_b_addr(mem_b_addr),
    .mem_a_data(mem_a_data),
    .mem_b_data(mem_b_data),
    .mac_start (mac_start),
    .mac_valid (mac_valid),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_result(mac_result),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Synchronous RAMs: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (mem_a_rd) mem_a_data <= memA[mem_a_addr];
    if (mem_b_rd) mem_b_data <= memB[mem_b_addr];
  end

  // Downstream MAC: start loads a*b, valid accumulates, result registered.
  always @(posedge clk) begin
    if (mac_start)      macAcc <= int'($signed(mac_a)) * int'($signed(mac_b));
    else if (mac_valid) macAcc <= macAcc + int'($signed(mac_a)) * int'($signed(mac_b));
  end
  assign mac_result = macAcc;

  // Activity monitor, sampled mid-cycle; addresses are checked against base+index mod 256.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        monBaseA = cmd_base_a;
        monBaseB = cmd_base_b;
        monIdxA  = 0;
        monIdxB  = 0;
      end
      if (mem_a_rd) begin
        if (mem_a_addr != 8'(int'(monBaseA) + monIdxA)) addrErrs++;
        monIdxA++;
        rdA++;
      end
      if (mem_b_rd) begin
        if (mem_b_addr != 8'(int'(monBaseB) + monIdxB)) addrErrs++;
        monIdxB++;
        rdB++;
      end
      if (mac_start) startCnt++;
      if (mac_valid) validCnt++;
      if (mac_start && mac_valid) overlapCnt++;
    end
  end

  function automatic longint refDot(input int len, input int bA, input int bB);
    longint s;
    int     r;
    s = 0;
    for (int i = 0; i < len; i++)
      s += longint'(memA[(bA + i) % 256]) * longint'(memB[(bB + i) % 256]);
    r = int'(s);
`ifdef MLP_MAC_CTRL_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return longint'(r);
  endfunction

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Issue one command, time the result, optionally stall res_ready, then check activity counts.
  task automatic applyStimulus(input int len, input int bA, input int bB, input int hold,
                               input string nm);
    int          k, bad;
    int          s0, s1, s2, s3, s4, s5;
    logic [31:0] held;
    longint      expv;
    expv = refDot(len, bA, bB);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    checkOutput({nm, "_cmd_ready"}, longint'(cmd_ready), 1);
    res_ready = (hold == 0);
    s0 = rdA; s1 = rdB; s2 = startCnt; s3 = validCnt; s4 = overlapCnt; s5 = addrErrs;
    cmd_valid  = 1'b1;
    cmd_len    = 9'(len);
    cmd_base_a = 8'(bA);
    cmd_base_b = 8'(bB);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 400) begin
      @(posedge clk); #1; k++;
    end
    checkOutput({nm, "_latency"}, k, (len == 0) ? 0 : len + 3);
    checkOutput({nm, "_data"}, longint'($signed(res_data)), expv);
    if (hold > 0) begin
      held = res_data;
      bad  = 0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!res_valid || res_data !== held || cmd_ready) bad++;
      end
      checkOutput({nm, "_hold_stable"}, bad, 0);
      res_ready = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput({nm, "_valid_drop"}, longint'(res_valid), 0);
    checkOutput({nm, "_back_idle"}, longint'(cmd_ready), 1);
    res_ready = 1'b1;
    checkOutput({nm, "_rd_a"}, rdA - s0, len);
    checkOutput({nm, "_rd_b"}, rdB - s1, len);
    checkOutput({nm, "_starts"}, startCnt - s2, (len > 0) ? 1 : 0);
    checkOutput({nm, "_valids"}, validCnt - s3, (len > 0) ? len - 1 : 0);
    checkOutput({nm, "_overlap"}, overlapCnt - s4, 0);
    checkOutput({nm, "_addr"}, addrErrs - s5, 0);
  endtask

  initial begin
    int vA[4];
    int vB[4];
    int bad;
    vA = '{3, -1, 4, 1};
    vB = '{2, 5, -2, 10};
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_len    = '0;
    cmd_base_a = '0;
    cmd_base_b = '0;
    res_ready  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'($urandom);
      memB[i] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_res_valid", longint'(res_valid), 0);
    checkOutput("rst_res_data", longint'(res_data), 0);
    checkOutput("rst_mem_rd", longint'({mem_a_rd, mem_b_rd}), 0);
    checkOutput("rst_mem_addr", longint'({mem_a_addr, mem_b_addr}), 0);
    checkOutput("rst_mac_ctl", longint'({mac_start, mac_valid}), 0);
    checkOutput("rst_mac_ab", longint'({mac_a, mac_b}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_cmd_ready", longint'(cmd_ready), 1);

    for (int i = 0; i < 4; i++) begin
      memA[i]      = 8'(vA[i]);
      memB[16 + i] = 8'(vB[i]);
    end
    applyStimulus(4, 0, 16, 0, "basic4");
    checkOutput("basic4_value", longint'($signed(res_data)), 3);

    applyStimulus(0, 7, 9, 0, "len0");
    checkOutput("len0_value", longint'($signed(res_data)), 0);

    applyStimulus(4, 0, 16, 5, "hold4");

    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'sd127;
      memB[i] = 8'sd127;
    end
    applyStimulus(256, 0, 0, 0, "full_pos");
`ifdef MLP_MAC_CTRL_SAT_EN
    checkOutput("full_pos_value", longint'($signed(res_data)), 32767);
    for (int i = 0; i < 256; i++) memA[i] = -8'sd128;
    applyStimulus(256, 0, 0, 0, "full_neg");
    checkOutput("full_neg_value", longint'($signed(res_data)), -32768);
`else
    checkOutput("full_pos_value", longint'($signed(res_data)), 4129024);
`endif

    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'($urandom);
      memB[i] = 8'($urandom);
    end
    applyStimulus(4, 254, 100, 0, "wrap");

    // Abort a len=8 command with a reset pulse mid-stream.
    cmd_valid  = 1'b1;
    cmd_len    = 9'd8;
    cmd_base_a = 8'd10;
    cmd_base_b = 8'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_in_reset", longint'({res_valid, mem_a_rd, mac_start, mac_valid}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid) bad++;
    end
    checkOutput("abort_no_valid", bad, 0);
    for (int i = 0; i < 4; i++) begin
      memA[i]      = 8'(vA[i]);
      memB[16 + i] = 8'(vB[i]);
    end
    applyStimulus(4, 0, 16, 0, "after_abort");
    checkOutput("after_abort_value", longint'($signed(res_data)), 3);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) begin
        memA[i] = 8'($urandom);
        memB[i] = 8'($urandom);
      end
      applyStimulus(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
